mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Two-requester arbiter for the load/store port (port B) of basic_mem, so the CPU and one peripheral master (program loader / DMA / display fetch) share it. Port A (PC fetch) is not touched. The block latches the winning request, drives the memory port from registers, captures read data, and returns a one-cycle ack. Sits between CPU/peripheral and basic_mem inside Bananachine.

Parameters:
WIDTH, 16, data and address width in bits
CPU_PRIORITY, 0, 0 = round-robin between requesters; 1 = CPU always wins ties

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU requests an access; held until cpu_ack
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  WIDTH  CPU word address
cpu_wdata  input  WIDTH  CPU write data
cpu_ack  output  1  one-cycle pulse: CPU access complete; rdata valid if read
dev_req  input  1  peripheral requests an access; held until dev_ack
dev_we  input  1  1 = write, 0 = read
dev_addr  input  WIDTH  peripheral word address
dev_wdata  input  WIDTH  peripheral write data
dev_ack  output  1  one-cycle pulse: peripheral access complete
rdata  output  WIDTH  registered read data, shared; qualified by cpu_ack/dev_ack
busy  output  1  high in any state other than IDLE
mem_addr  output  WIDTH  to basic_mem addr_b
mem_data  output  WIDTH  to basic_mem data_b
mem_we  output  1  to basic_mem we_b
mem_reading_for_load  output  1  to basic_mem reading_for_load
mem_q  input  WIDTH  from basic_mem q_b; valid the cycle after address is sampled

Behaviour:
- Reset (async): state=IDLE, last_owner=DEV (so CPU wins first tie), all outputs 0, latched request registers 0.
- States: IDLE, ACCESS, CAPTURE, RESPOND.
- IDLE: if any req, pick owner; latch owner, we, addr, wdata; -> ACCESS. No req: stay.
- Arbitration: only one req -> that one. Both: CPU_PRIORITY=1 -> CPU; else the requester not equal to last_owner. last_owner updated on grant.
- ACCESS (1 cycle): mem_addr=latched addr; write: mem_we=1, mem_data=latched wdata, -> RESPOND; read: mem_reading_for_load=1, mem_we=0, -> CAPTURE.
- CAPTURE (reads only): rdata <= mem_q at end of cycle; -> RESPOND.
- RESPOND: owner's ack=1 for exactly this cycle; -> IDLE. Requester deasserts or re-presents req in the next cycle; a req still high in the IDLE cycle after RESPOND is a new request.
- mem_we and mem_reading_for_load are 0 outside ACCESS; mem_addr/mem_data hold last values (don't care).
- Latency, req high in IDLE cycle 0: write ack in cycle 2, read ack in cycle 3. Minimum spacing between grants: 3 cycles (write), 4 cycles (read).
- rdata holds its value until the next read capture; after writes it is unchanged.
- Inputs are sampled only in IDLE; a req dropped mid-transaction does not cancel it, and the ack still pulses.
- cpu_ack and dev_ack are never high together.
- Reset mid-transaction: returns to IDLE at once, no ack, mem_we drops to 0 asynchronously; no write is issued after reset deasserts.
- Address/data pass through unmodified; no wrap or width conversion.

Test Plan:
1. Reset, CPU write addr 0x0010 data 0xBEEF -> mem_we=1 with mem_addr=0x0010, mem_data=0xBEEF for exactly 1 cycle; cpu_ack in cycle 2; dev_ack stays 0.
2. Dev read addr 0x0010, model returns 0xBEEF -> mem_reading_for_load high 1 cycle; dev_ack in cycle 3 with rdata=0xBEEF; busy high cycles 1-3.
3. Both req held continuously, CPU_PRIORITY=0 -> grants alternate CPU, DEV, CPU, DEV, with CPU first after reset; no double ack.
4. Same stimulus with CPU_PRIORITY=1 -> CPU served every grant; dev_ack never pulses while cpu_req stays high.
5. Assert reset during ACCESS of a dev write -> mem_we falls immediately, no ack, state IDLE; after release, mem_we stays 0 until a new req.
6. CPU read where cpu_req drops in ACCESS and cpu_addr changes to 0x0FFF -> mem_addr keeps the original address; cpu_ack still pulses; rdata holds the original word.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle for the shared load/store port: CPU and peripheral request channels,
// the shared read-data return, and the basic_mem port-B wiring.
interface mem_port_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             cpu_req;
    logic             cpu_we;
    logic [WIDTH-1:0] cpu_addr;
    logic [WIDTH-1:0] cpu_wdata;
    logic             cpu_ack;

    logic             dev_req;
    logic             dev_we;
    logic [WIDTH-1:0] dev_addr;
    logic [WIDTH-1:0] dev_wdata;
    logic             dev_ack;

    logic [WIDTH-1:0] rdata;
    logic             busy;

    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic             mem_we;
    logic             mem_reading_for_load;
    logic [WIDTH-1:0] mem_q;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dev_req, dev_we, dev_addr, dev_wdata,
        input  mem_q,
        output cpu_ack, dev_ack, rdata, busy,
        output mem_addr, mem_data, mem_we, mem_reading_for_load
    );

    // Requesters and memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dev_req, dev_we, dev_addr, dev_wdata,
        output mem_q,
        input  cpu_ack, dev_ack, rdata, busy,
        input  mem_addr, mem_data, mem_we, mem_reading_for_load
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for basic_mem port B: latches the winning request,
// drives the memory port from registers, captures read data, pulses one ack.
module mem_port_arbiter #(
    parameter int WIDTH        = 16,
    parameter bit CPU_PRIORITY = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DEV = 1'b1
    } owner_t;

    state_t           state_r;
    state_t           state_s;
    owner_t           owner_r;
    owner_t           owner_s;
    owner_t           last_owner_r;
    owner_t           last_owner_s;
    logic             we_r;
    logic             we_s;
    logic [WIDTH-1:0] addr_r;
    logic [WIDTH-1:0] addr_s;
    logic [WIDTH-1:0] wdata_r;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] rdata_r;
    logic             mem_we_r;
    logic             reading_r;
    logic             cpu_ack_r;
    logic             dev_ack_r;
    logic             busy_r;

    // On a tie, round-robin hands the grant to whoever did not win last time
    function automatic logic grant_cpu(input logic req_cpu,
                                       input logic req_dev,
                                       input logic last_was_dev);
        logic g;
        if (!req_cpu) begin
            g = 1'b0;
        end else if (!req_dev) begin
            g = 1'b1;
        end else if (CPU_PRIORITY == 1'b1) begin
            g = 1'b1;
        end else begin
            g = last_was_dev;
        end
        return g;
    endfunction

    // Next-state logic and request latching
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        we_s         = we_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.cpu_req || bus.dev_req) begin
                    if (grant_cpu(bus.cpu_req, bus.dev_req, last_owner_r == OWN_DEV)) begin
                        owner_s      = OWN_CPU;
                        last_owner_s = OWN_CPU;
                        we_s         = bus.cpu_we;
                        addr_s       = bus.cpu_addr;
                        wdata_s      = bus.cpu_wdata;
                    end else begin
                        owner_s      = OWN_DEV;
                        last_owner_s = OWN_DEV;
                        we_s         = bus.dev_we;
                        addr_s       = bus.dev_addr;
                        wdata_s      = bus.dev_wdata;
                    end
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (we_r) begin
                    state_s = ST_RESPOND;
                end else begin
                    state_s = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_s = ST_RESPOND;
            ST_RESPOND: state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // State and latched request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_CPU;
            last_owner_r <= OWN_DEV;
            we_r         <= 1'b0;
            addr_r       <= {WIDTH{1'b0}};
            wdata_r      <= {WIDTH{1'b0}};
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            we_r         <= we_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
        end
    end

    // Strobes are registered from the next state so they line up with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we_r  <= 1'b0;
            reading_r <= 1'b0;
            cpu_ack_r <= 1'b0;
            dev_ack_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            mem_we_r  <= (state_s == ST_ACCESS) && we_s;
            reading_r <= (state_s == ST_ACCESS) && !we_s;
            cpu_ack_r <= (state_s == ST_RESPOND) && (owner_s == OWN_CPU);
            dev_ack_r <= (state_s == ST_RESPOND) && (owner_s == OWN_DEV);
            busy_r    <= (state_s != ST_IDLE);
        end
    end

    // Read data is taken from memory only in CAPTURE and held otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r <= {WIDTH{1'b0}};
        end else if (state_r == ST_CAPTURE) begin
            rdata_r <= bus.mem_q;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign bus.mem_addr             = addr_r;
    assign bus.mem_data             = wdata_r;
    assign bus.mem_we               = mem_we_r;
    assign bus.mem_reading_for_load = reading_r;
    assign bus.cpu_ack              = cpu_ack_r;
    assign bus.dev_ack              = dev_ack_r;
    assign bus.rdata                = rdata_r;
    assign bus.busy                 = busy_r;

endmodule
